// File: rtl/abs_frame_accum.sv
// Streaming absolute-value stage with per-sample magnitude output and
// fixed-length frame sums of magnitudes handed off through valid/ready.
module abs_frame_accum #(
  parameter int DATA_WIDTH = 11,
  parameter int FRAME_LEN  = 16,
  parameter bit SAT_MODE   = 1'b1,
  localparam int ACC_WIDTH = (DATA_WIDTH - 1) + $clog2(FRAME_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic                    abs_valid,
  output logic [DATA_WIDTH-2:0]   abs_out,
  output logic                    abs_sat,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [ACC_WIDTH-1:0]    sum_out,
  output logic                    sum_sat
);

  localparam int MAG_W = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   sat_acc;
  logic [CNT_W-1:0]       cnt;

  logic [DATA_WIDTH-1:0]  neg_in;
  logic [MAG_W-1:0]       mag;
  logic                   min_neg;
  logic                   accept;
  logic                   last;
  logic [ACC_WIDTH-1:0]   acc_sum;

  assign in_ready = (state == ACCUM) & ~rst;
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == LAST);
  assign acc_sum  = acc + ACC_WIDTH'(mag);

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    neg_in  = ~in + DATA_WIDTH'(1);
    min_neg = (in == {1'b1, {MAG_W{1'b0}}});
    mag     = in[DATA_WIDTH-1] ? neg_in[MAG_W-1:0] : in[MAG_W-1:0];
    // The most-negative value has no positive twin; its low bits are zero.
    if (min_neg) mag = SAT_MODE ? {MAG_W{1'b1}} : {MAG_W{1'b0}};
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last) state_next = HOLD;
        HOLD:    if (sum_ready)      state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_valid <= 1'b0;
      abs_out   <= '0;
      abs_sat   <= 1'b0;
    end else begin
      abs_valid <= accept;
      if (accept) begin
        abs_out <= mag;
        abs_sat <= min_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sat_acc   <= 1'b0;
      cnt       <= '0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      sum_sat   <= 1'b0;
    end else if (clr) begin
      // A sample accepted alongside clr is reported but starts no frame.
      acc       <= '0;
      sat_acc   <= 1'b0;
      cnt       <= '0;
      sum_valid <= 1'b0;
    end else if (accept) begin
      if (last) begin
        sum_out   <= acc_sum;
        sum_sat   <= sat_acc | min_neg;
        sum_valid <= 1'b1;
        acc       <= '0;
        sat_acc   <= 1'b0;
        cnt       <= '0;
      end else begin
        acc     <= acc_sum;
        sat_acc <= sat_acc | min_neg;
        cnt     <= cnt + CNT_W'(1);
      end
    end else if (state == HOLD && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abs_frame_accum.sv
// Self-checking bench: directed cases plus random traffic against a queue-based
// frame model, with a saturating and a wrapping instance driven in parallel.
module tb_abs_frame_accum;

  localparam int W    = 11;
  localparam int FL   = 4;
  localparam int AW   = (W - 1) + $clog2(FL);
  localparam int MINV = -(1 << (W - 1));
  localparam int MAXV = (1 << (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in = '0;
  logic          sum_ready = 1'b0;

  logic          in_ready_s, abs_valid_s, abs_sat_s, sum_valid_s, sum_sat_s;
  logic [W-2:0]  abs_out_s;
  logic [AW-1:0] sum_out_s;
  logic          in_ready_w, abs_valid_w, abs_sat_w, sum_valid_w, sum_sat_w;
  logic [W-2:0]  abs_out_w;
  logic [AW-1:0] sum_out_w;

  abs_frame_accum #(.DATA_WIDTH(W), .FRAME_LEN(FL), .SAT_MODE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .in(in), .abs_valid(abs_valid_s), .abs_out(abs_out_s), .abs_sat(abs_sat_s),
    .sum_valid(sum_valid_s), .sum_ready(sum_ready), .sum_out(sum_out_s),
    .sum_sat(sum_sat_s)
  );

  abs_frame_accum #(.DATA_WIDTH(W), .FRAME_LEN(FL), .SAT_MODE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .in(in), .abs_valid(abs_valid_w), .abs_out(abs_out_w), .abs_sat(abs_sat_w),
    .sum_valid(sum_valid_w), .sum_ready(sum_ready), .sum_out(sum_out_w),
    .sum_sat(sum_sat_w)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int frame_q[$];
  bit m_hold, m_abs_valid, m_abs_sat, m_sum_valid, m_sum_sat;
  int m_abs_s, m_abs_w, m_sum_s, m_sum_w;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int mag(input int s, input bit sat);
    if (s == MINV) return sat ? MAXV : 0;
    return (s < 0) ? -s : s;
  endfunction

  task automatic check_outputs();
    check("abs_valid_s", abs_valid_s, m_abs_valid);
    check("abs_valid_w", abs_valid_w, m_abs_valid);
    check("abs_out_s",   abs_out_s,   m_abs_s);
    check("abs_out_w",   abs_out_w,   m_abs_w);
    check("abs_sat_s",   abs_sat_s,   m_abs_sat);
    check("abs_sat_w",   abs_sat_w,   m_abs_sat);
    check("sum_valid_s", sum_valid_s, m_sum_valid);
    check("sum_valid_w", sum_valid_w, m_sum_valid);
    check("sum_out_s",   sum_out_s,   m_sum_s);
    check("sum_out_w",   sum_out_w,   m_sum_w);
    check("sum_sat_s",   sum_sat_s,   m_sum_sat);
    check("sum_sat_w",   sum_sat_w,   m_sum_sat);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check outputs.
  task automatic cycle(input bit v, input int sample, input bit c, input bit sr);
    bit acc_now;
    int s_tot, w_tot;
    bit any_sat;
    in_valid  = v;
    in        = v ? sample[W-1:0] : W'($urandom);
    clr       = c;
    sum_ready = sr;
    #1;
    check("in_ready_s", in_ready_s, !m_hold);
    check("in_ready_w", in_ready_w, !m_hold);
    acc_now = v && !m_hold;
    m_abs_valid = acc_now;
    if (acc_now) begin
      m_abs_s   = mag(sample, 1'b1);
      m_abs_w   = mag(sample, 1'b0);
      m_abs_sat = (sample == MINV);
    end
    if (c) begin
      frame_q.delete();
      m_hold      = 1'b0;
      m_sum_valid = 1'b0;
    end else if (acc_now) begin
      frame_q.push_back(sample);
      if (frame_q.size() == FL) begin
        s_tot = 0; w_tot = 0; any_sat = 1'b0;
        foreach (frame_q[i]) begin
          s_tot += mag(frame_q[i], 1'b1);
          w_tot += mag(frame_q[i], 1'b0);
          any_sat |= (frame_q[i] == MINV);
        end
        m_sum_s = s_tot; m_sum_w = w_tot; m_sum_sat = any_sat;
        m_sum_valid = 1'b1;
        m_hold      = 1'b1;
        frame_q.delete();
      end
    end else if (m_hold && sr) begin
      m_hold      = 1'b0;
      m_sum_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in        = W'($urandom);
      sum_ready = 1'($urandom);
      #1;
      check("in_ready_rst_s", in_ready_s, 0);
      check("in_ready_rst_w", in_ready_w, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    frame_q.delete();
    m_hold = 0; m_abs_valid = 0; m_abs_sat = 0; m_sum_valid = 0; m_sum_sat = 0;
    m_abs_s = 0; m_abs_w = 0; m_sum_s = 0; m_sum_w = 0;
    check_outputs();
  endtask

  initial begin
    do_reset(2);

    // Basic magnitudes and the most-negative input in both modes
    cycle(1, -5, 0, 0);
    check("t1_abs_neg5", abs_out_s, 5);
    cycle(1, 5, 0, 0);
    cycle(1, MINV, 0, 0);
    check("t2_sat", abs_out_s, 1023);
    check("t2_wrap", abs_out_w, 0);
    cycle(0, 0, 0, 0);

    // Frame back-to-back, then backpressure for 5 cycles
    cycle(0, 0, 1, 0);
    cycle(1, 3, 0, 0);
    cycle(1, -4, 0, 0);
    cycle(1, 1023, 0, 0);
    cycle(1, -1023, 0, 0);
    check("t3_sum", sum_out_s, 2053);
    for (int i = 0; i < 5; i++) cycle(1, 77, 0, 0);
    cycle(1, 9, 0, 1);
    cycle(0, 0, 0, 0);

    // Four most-negative samples: full-scale sum without wrap
    for (int i = 0; i < 4; i++) cycle(1, MINV, 0, 0);
    check("t4_sum", sum_out_s, 4092);
    check("t4_sat", sum_sat_s, 1);
    cycle(0, 0, 0, 1);

    // clr mid-frame with gaps in in_valid
    cycle(1, 7, 0, 0);
    cycle(1, 7, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("t5_sum", sum_out_s, 4);
    cycle(0, 0, 0, 1);

    // Reset while holding a frame sum; next sum covers only new samples
    for (int i = 0; i < 4; i++) cycle(1, 100 + i, 0, 0);
    cycle(0, 0, 0, 0);
    do_reset(1);
    cycle(1, 10, 0, 0);
    cycle(1, -20, 0, 0);
    cycle(1, 30, 0, 0);
    cycle(1, -40, 0, 0);
    check("t6_sum", sum_out_s, 100);
    cycle(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? MINV : (int'($urandom_range(0, 2047)) - 1024);
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 40) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
